// File: rtl/cache_pkg.sv
// Shared definitions for the two-requester cache port arbiter.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT     = 3;
  localparam int MAX_BURST_DEFAULT = 4;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick; a held owner always wins and is identified by
// the last-grant pointer, since the owner is by construction the last granted.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       hold,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    grant = 1'b0;
    valid = 1'b0;
    if (hold) begin
      grant = last;
      valid = 1'b1;
    end else if (req == 2'b11) begin
      grant = ~last;
      valid = 1'b1;
    end else if (req[0]) begin
      grant = 1'b0;
      valid = 1'b1;
    end else if (req[1]) begin
      grant = 1'b1;
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Arbitrates two requesters onto one registered output beat with locked
// bursts capped at MAX_BURST and round-robin fairness otherwise.
//
// state | meaning
// IDLE  | no beat held; every cycle is a capture slot
// OWN0  | out_data holds a beat from requester 0
// OWN1  | out_data holds a beat from requester 1
module cache_port_arbiter
  import cache_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_0,
  input  logic [WIDTH-1:0] din_0,
  input  logic             lock_0,
  output logic             gnt_0,
  input  logic             req_1,
  input  logic [WIDTH-1:0] din_1,
  input  logic             lock_1,
  output logic             gnt_1,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  state_t     state;
  logic [3:0] burst_cnt;
  logic       last_grant;
  logic       capture;
  logic       own_lock;
  logic       hold;
  logic       pick;
  logic       pick_valid;
  logic       take;

  assign capture  = (state == IDLE) || (out_valid && out_ready);
  assign own_lock = ((state == OWN0) && req_0 && lock_0) ||
                    ((state == OWN1) && req_1 && lock_1);
  // At the cap the owner's lock is ignored and it competes like anyone else.
  assign hold     = own_lock && (burst_cnt < 4'(MAX_BURST));

  rr_pick2 u_pick (
    .req   ({req_1, req_0}),
    .last  (last_grant),
    .hold  (hold),
    .grant (pick),
    .valid (pick_valid)
  );

  assign take  = rst_n && capture && pick_valid;
  assign gnt_0 = take && !pick;
  assign gnt_1 = take && pick;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      burst_cnt  <= 4'd0;
      last_grant <= 1'b1;
    end else if (capture) begin
      if (pick_valid) begin
        out_valid  <= 1'b1;
        out_data   <= pick ? din_1 : din_0;
        sel        <= pick;
        state      <= pick ? OWN1 : OWN0;
        last_grant <= pick;
        burst_cnt  <= hold ? burst_cnt + 4'd1 : 4'd1;
      end else begin
        out_valid <= 1'b0;
        state     <= IDLE;
        burst_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Randomized and directed checks of cache_port_arbiter against a cycle model.
module tb_cache_port_arbiter;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_0, req_1, lock_0, lock_1, out_ready;
  logic [2:0] din_0, din_1;
  logic       gnt_0, gnt_1, sel, out_valid;
  logic [2:0] out_data;

  cache_port_arbiter #(.WIDTH(3), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .din_0(din_0), .lock_0(lock_0), .gnt_0(gnt_0),
    .req_1(req_1), .din_1(din_1), .lock_1(lock_1), .gnt_1(gnt_1),
    .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // model: owner -1 means nothing held
  int         m_owner;
  bit         m_valid, m_sel, m_last;
  logic [2:0] m_data;
  int         m_cnt;

  int vectors = 0;
  int miscompares = 0;

  bit         s_g0, s_g1, s_v, s_sel;
  logic [2:0] s_d;

  function automatic void model_reset();
    m_owner = -1; m_valid = 0; m_sel = 0; m_last = 1; m_data = 3'd0; m_cnt = 0;
  endfunction

  function automatic void model_pick(output int p, output bit locked);
    bit cap;
    bit owner_locked;
    p = -1;
    locked = 0;
    cap = (m_owner < 0) || (m_valid && out_ready);
    if (!rst_n || !cap) return;
    owner_locked = (m_owner == 0) ? (req_0 && lock_0) : (m_owner == 1) ? (req_1 && lock_1) : 1'b0;
    if (owner_locked && m_cnt < MAXB) begin
      p = m_owner;
      locked = 1;
    end else if (req_0 && req_1) p = m_last ? 0 : 1;
    else if (req_0) p = 0;
    else if (req_1) p = 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    int p;
    bit lk;
    bit cap;
    @(negedge clk);
    model_pick(p, lk);
    s_g0 = gnt_0; s_g1 = gnt_1; s_v = out_valid; s_sel = sel; s_d = out_data;
    chk("gnt_0", int'(gnt_0), int'(p == 0));
    chk("gnt_1", int'(gnt_1), int'(p == 1));
    chk("out_valid", int'(out_valid), int'(m_valid));
    chk("sel", int'(sel), int'(m_sel));
    chk("out_data", int'(out_data), int'(m_data));
    @(posedge clk);
    cap = (m_owner < 0) || (m_valid && out_ready);
    if (!rst_n) model_reset();
    else if (cap) begin
      if (p >= 0) begin
        m_cnt   = (lk && p == m_owner) ? m_cnt + 1 : 1;
        m_valid = 1;
        m_data  = (p == 0) ? din_0 : din_1;
        m_sel   = (p == 1);
        m_last  = (p == 1);
        m_owner = p;
      end else begin
        m_valid = 0;
        m_owner = -1;
        m_cnt   = 0;
      end
    end
    #1;
  endtask

  task automatic quiet();
    req_0 = 0; req_1 = 0; lock_0 = 0; lock_1 = 0; din_0 = 0; din_1 = 0; out_ready = 1;
  endtask

  task automatic do_reset();
    quiet();
    rst_n = 0;
    cycle();
    rst_n = 1;
  endtask

  initial begin
    quiet();
    rst_n = 0;
    model_reset();
    @(posedge clk);
    #1;

    // reset state
    cycle();
    chk("pin_reset_valid", int'(s_v), 0);
    chk("pin_reset_sel", int'(s_sel), 0);
    chk("pin_reset_data", int'(s_d), 0);
    rst_n = 1;

    // single request, then idle return
    req_0 = 1; din_0 = 3'b101;
    cycle();
    chk("pin_single_gnt0", int'(s_g0), 1);
    req_0 = 0;
    cycle();
    chk("pin_single_valid", int'(s_v), 1);
    chk("pin_single_data", int'(s_d), 5);
    chk("pin_single_sel", int'(s_sel), 0);
    cycle();
    chk("pin_idle_valid", int'(s_v), 0);
    req_1 = 1; din_1 = 3'd3;
    cycle();
    chk("pin_r1_gnt1", int'(s_g1), 1);
    req_1 = 0;
    cycle();
    chk("pin_r1_sel", int'(s_sel), 1);
    cycle();
    chk("pin_idle_sel_held", int'(s_sel), 1);
    chk("pin_idle_valid2", int'(s_v), 0);
    out_ready = 0; req_0 = 1; din_0 = 3'd4;
    cycle();
    chk("pin_idle_capture", int'(s_g0), 1);

    // tie fairness
    do_reset();
    req_0 = 1; req_1 = 1; din_0 = 3'd1; din_1 = 3'd2;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("pin_tie_g0", int'(s_g0), int'(k % 2 == 0));
      chk("pin_tie_g1", int'(s_g1), int'(k % 2 == 1));
      if (k > 0) chk("pin_tie_sel", int'(s_sel), (k - 1) % 2);
    end

    // burst cap
    do_reset();
    req_0 = 1; lock_0 = 1; req_1 = 1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("pin_burst_g0", int'(s_g0), int'(k != 4));
      chk("pin_burst_g1", int'(s_g1), int'(k == 4));
    end

    // backpressure
    do_reset();
    req_0 = 1; din_0 = 3'd2; out_ready = 0;
    cycle();
    chk("pin_bp_first", int'(s_g0), 1);
    din_0 = 3'd6;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("pin_bp_nognt", int'(s_g0), 0);
      chk("pin_bp_data", int'(s_d), 2);
      chk("pin_bp_valid", int'(s_v), 1);
    end
    out_ready = 1;
    cycle();
    chk("pin_bp_release", int'(s_g0), 1);
    cycle();
    chk("pin_bp_newdata", int'(s_d), 6);

    // reset mid-operation
    req_0 = 0; req_1 = 1; din_1 = 3'd7;
    cycle();
    req_0 = 1;
    rst_n = 0;
    cycle();
    chk("pin_rst_sel_before", int'(s_sel), 1);
    chk("pin_rst_nogrant", int'(s_g0 | s_g1), 0);
    rst_n = 1;
    cycle();
    chk("pin_rst_valid", int'(s_v), 0);
    chk("pin_rst_sel", int'(s_sel), 0);
    chk("pin_rst_tie_g0", int'(s_g0), 1);
    chk("pin_rst_tie_g1", int'(s_g1), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 149) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!req_0 || s_g0) din_0 = 3'($urandom_range(0, 7));
      if (!req_1 || s_g1) din_1 = 3'($urandom_range(0, 7));
      if (!req_0 || s_g0) req_0 = ($urandom_range(0, 3) != 0);
      if (!req_1 || s_g1) req_1 = ($urandom_range(0, 2) != 0);
      lock_0 = ($urandom_range(0, 2) != 0);
      lock_1 = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
